// File: rtl/unsigned_divider_pkg.sv
// Shared types and constants for the unsigned sequential divider.
package unsigned_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // Iteration counter width: must be able to hold DATA_WIDTH itself.
    function automatic int count_width(input int data_width);
        return $clog2(data_width) + 1;
    endfunction

endpackage

// File: rtl/unsigned_divider_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract B,
// keep the difference when it does not borrow.
module unsigned_divider_step
    import unsigned_divider_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] r_in,
    input  logic [DATA_WIDTH-1:0] q_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic [DATA_WIDTH-1:0] r_next,
    output logic [DATA_WIDTH-1:0] q_next
);

    logic [DATA_WIDTH:0] r_shift;
    logic [DATA_WIDTH:0] diff;
    logic                fits;

    // Trial subtraction is one bit wider than the operands so the shifted
    // remainder can never overflow; a clear top bit means R_shifted >= B.
    always_comb begin
        r_shift = {r_in, q_in[DATA_WIDTH-1]};
        diff    = r_shift - {1'b0, b_in};
        fits    = ~diff[DATA_WIDTH];
        r_next  = fits ? diff[DATA_WIDTH-1:0] : r_shift[DATA_WIDTH-1:0];
        q_next  = {q_in[DATA_WIDTH-2:0], fits};
    end

endmodule

// File: rtl/unsigned_sequential_divider.sv
// Iterative restoring unsigned divider, one quotient bit per enabled clock,
// with a start/done handshake and a divide-by-zero shortcut.
module unsigned_sequential_divider
    import unsigned_divider_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    input  logic                  Enable_In,
    input  logic                  Start_In,
    input  logic [DATA_WIDTH-1:0] Data_A_In,
    input  logic [DATA_WIDTH-1:0] Data_B_In,
    output logic                  Busy_Out,
    output logic                  Done_Out,
    output logic [DATA_WIDTH-1:0] Quotient_Out,
    output logic [DATA_WIDTH-1:0] Remainder_Out,
    output logic                  Div_By_Zero_Out
);

    localparam int COUNT_WIDTH = count_width(DATA_WIDTH);

    div_state_t             state;
    div_state_t             state_next;
    logic [COUNT_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0]  rem_reg;
    logic [DATA_WIDTH-1:0]  quo_reg;
    logic [DATA_WIDTH-1:0]  div_reg;
    logic [DATA_WIDTH-1:0]  rem_next;
    logic [DATA_WIDTH-1:0]  quo_next;
    logic                   last_iter;

    assign last_iter = (count == COUNT_WIDTH'(DATA_WIDTH - 1));

    unsigned_divider_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .r_in  (rem_reg),
        .q_in  (quo_reg),
        .b_in  (div_reg),
        .r_next(rem_next),
        .q_next(quo_next)
    );

    // State register; a low enable freezes the FSM.
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state <= IDLE;
        end else if (Enable_In) begin
            state <= state_next;
        end
    end

    // Next state: starts are only honoured outside RUN; a zero divisor skips RUN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (Start_In) begin
                    state_next = (Data_B_In == '0) ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in RUN, publish results at the end.
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            count           <= '0;
            rem_reg         <= '0;
            quo_reg         <= '0;
            div_reg         <= '0;
            Quotient_Out    <= '0;
            Remainder_Out   <= '0;
            Div_By_Zero_Out <= 1'b0;
        end else if (Enable_In) begin
            case (state)
                IDLE, DONE: begin
                    if (Start_In) begin
                        if (Data_B_In == '0) begin
                            Quotient_Out    <= '1;
                            Remainder_Out   <= Data_A_In;
                            Div_By_Zero_Out <= 1'b1;
                        end else begin
                            div_reg         <= Data_B_In;
                            quo_reg         <= Data_A_In;
                            rem_reg         <= '0;
                            count           <= '0;
                            Quotient_Out    <= '0;
                            Remainder_Out   <= '0;
                            Div_By_Zero_Out <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    count   <= count + COUNT_WIDTH'(1);
                    if (last_iter) begin
                        Quotient_Out  <= quo_next;
                        Remainder_Out <= rem_next;
                    end
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

    // Status outputs decode directly from the state.
    always_comb begin
        Busy_Out = (state == RUN);
        Done_Out = (state == DONE);
    end

endmodule

// File: doc/unsigned_sequential_divider.md
Name: unsigned_sequential_divider

Overview:
Iterative restoring divider for unsigned operands. It computes quotient and remainder one bit per clock, with a start/done handshake. It is the inverse-operation companion to the team's unsigned array multipliers and sits in the Arithmetic_and_Logic_Modules library. Its results are meant to be checked against Data_A_In / Data_B_In and also cross-checked with the multiplier: Quotient*B + Remainder == A.

Parameters:
DATA_WIDTH, 32, operand/result width in bits (>= 2).
COUNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
Clock_In  input  1  single clock; all state updates on the rising edge.
Reset_In  input  1  asynchronous, active-high reset.
Enable_In  input  1  clock enable; low freezes all state and outputs.
Start_In  input  1  request a division; sampled only when Enable_In=1.
Data_A_In  input  DATA_WIDTH  dividend; captured on accepted start.
Data_B_In  input  DATA_WIDTH  divisor; captured on accepted start.
Busy_Out  output  1  high while in RUN.
Done_Out  output  1  one-enabled-cycle pulse when results become valid.
Quotient_Out  output  DATA_WIDTH  quotient; held until the next accepted start.
Remainder_Out  output  DATA_WIDTH  remainder; held until the next accepted start.
Div_By_Zero_Out  output  1  high with a held result whose divisor was 0.

Behaviour:
- Reset (async assert, any state): state=IDLE, counter=0, internal registers=0, Busy_Out=0, Done_Out=0, Quotient_Out=0, Remainder_Out=0, Div_By_Zero_Out=0. Reset mid-division aborts it with no Done_Out.
- Enable_In=0: no register changes; a Done_Out already high stays high until the next enabled edge. Stall cycles add directly to latency.
- FSM states: IDLE, RUN, DONE.
- Start acceptance: only in IDLE or DONE with Enable_In=1 and Start_In=1. Start in RUN is ignored (no queuing).
- Accept with B!=0:
  - Operands are latched, the partial remainder is cleared, counter=0, next=RUN.
  - Quotient_Out, Remainder_Out and Div_By_Zero_Out are cleared to 0 on acceptance.
- Accept with B=0: next=DONE directly. Quotient_Out=all ones, Remainder_Out=A, Div_By_Zero_Out=1. Latency is 1 enabled edge.
- RUN, each enabled edge:
  - Shift {R,Q} left by 1, bringing in the next dividend MSB.
  - If R_shifted >= B: R = R_shifted - B and the quotient LSB = 1; otherwise the quotient LSB = 0.
  - The compare/subtract uses DATA_WIDTH+1 bits so it cannot overflow.
  - Counter increments; after DATA_WIDTH iterations, next=DONE and the outputs are loaded.
- Latency: Done_Out is high in the cycle after the (DATA_WIDTH+1)th enabled edge counted from acceptance. For DATA_WIDTH=32 that is 33 enabled edges.
- DONE: Done_Out=1 for exactly one enabled cycle. Next=IDLE, or RUN/DONE if a new start is accepted (back-to-back allowed). Results hold in IDLE.
- Busy_Out=1 exactly in RUN.
- Edge cases:
  - A < B: Q=0, R=A.
  - A=0: Q=0, R=0.
  - B=1: Q=A, R=0.
  - Full latency is used for all B!=0 (no early exit).

Decomposition:
- Package unsigned_divider_pkg: state enum (IDLE, RUN, DONE), default DATA_WIDTH constant, COUNT_WIDTH function.
- Sub-module unsigned_divider_step: combinational single-iteration shift/compare/subtract (inputs R, Q, B; outputs R_next, Q_next). It is instantiated once; the FSM/counter wrapper registers its outputs.

Test Plan:
- Reset then A=100, B=7, Start=1 for one cycle -> Busy_Out high for 32 cycles; Done_Out pulse after 33 edges; Q=14, R=2, Div_By_Zero_Out=0.
- A=5, B=0 -> after 1 edge Done_Out=1, Q=0xFFFFFFFF, R=5, Div_By_Zero_Out=1; Busy_Out never asserts.
- Boundary operands:
  - A=0xFFFFFFFF, B=1 -> Q=0xFFFFFFFF, R=0.
  - A=3, B=10 -> Q=0, R=3.
  - A=0xFFFFFFFF, B=0xFFFFFFFF -> Q=1, R=0.
- Start A=1000, B=3. Pulse Start again with A=9, B=9 at edge 10 -> ignored; result Q=333, R=1. Then Enable_In=0 for 5 cycles mid-RUN -> Done_Out delayed by exactly 5 cycles.
- Assert Reset_In asynchronously at edge 15 of a division -> all outputs 0 immediately, state IDLE, no Done_Out. A new start then completes correctly.
- 20 random A/B (including B=0) with back-to-back starts in DONE -> every result satisfies Q*B+R==A and R<B (or the Div_By_Zero rule); pass/fail counts are tallied.
